// File: rtl/alu_issue_pkg.sv
// Shared types and default widths for the ALU issue unit and its register file.
package alu_issue_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_CNT    = 16;
  localparam int unsigned REG_ADDR_W = $clog2(REG_CNT);
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned OPCODE_W   = 4;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src_a;
    logic [REG_ADDR_W-1:0] src_b;
    logic                  imm_en;
    logic [DATA_W-1:0]     imm;
  } inst_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } result_t;

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, R0 reads as zero.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned BITWIDTH = DATA_W,
  parameter int unsigned REGCOUNT = REG_CNT,
  localparam int unsigned REGADDR = $clog2(REGCOUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [REGADDR-1:0]  waddr,
  input  logic [BITWIDTH-1:0] wdata,
  input  logic [REGADDR-1:0]  raddr_a,
  output logic [BITWIDTH-1:0] rdata_a,
  input  logic [REGADDR-1:0]  raddr_b,
  output logic [BITWIDTH-1:0] rdata_b
);

  logic [BITWIDTH-1:0] mem_q [REGCOUNT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(REGCOUNT); i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/alu_issue_unit.sv
// Issues register-addressed ops to an external combinational ALU and holds each result
// in a one-entry valid/ready register, with issue and stall counters.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int unsigned BITWIDTH = DATA_W,
  parameter int unsigned REGCOUNT = REG_CNT,
  parameter int unsigned CNTWIDTH = CNT_W,
  localparam int unsigned REGADDR = $clog2(REGCOUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                InstValid,
  output logic                InstReady,
  input  logic [3:0]          InstOpcode,
  input  logic [REGADDR-1:0]  InstDest,
  input  logic [REGADDR-1:0]  InstSrcA,
  input  logic [REGADDR-1:0]  InstSrcB,
  input  logic                InstImmEn,
  input  logic [BITWIDTH-1:0] InstImm,
  output logic [BITWIDTH-1:0] Data_InA,
  output logic [BITWIDTH-1:0] Data_InB,
  output logic                ALU_Enable,
  output logic [3:0]          Opcode,
  input  logic [BITWIDTH-1:0] Data_OutC,
  output logic                ResultValid,
  input  logic                ResultReady,
  output logic [REGADDR-1:0]  ResultDest,
  output logic [BITWIDTH-1:0] ResultData,
  output logic [CNTWIDTH-1:0] IssueCount,
  output logic [CNTWIDTH-1:0] StallCount
);

  inst_t               inst_c;
  result_t             res_q;
  res_state_e          state_q;
  logic                fire_c;
  logic [BITWIDTH-1:0] rd_a_c;
  logic [BITWIDTH-1:0] rd_b_c;

  assign inst_c = '{opcode: OPCODE_W'(InstOpcode),
                    dest:   REG_ADDR_W'(InstDest),
                    src_a:  REG_ADDR_W'(InstSrcA),
                    src_b:  REG_ADDR_W'(InstSrcB),
                    imm_en: InstImmEn,
                    imm:    DATA_W'(InstImm)};

  // Accept a new op whenever the result slot is empty or is draining this cycle.
  assign InstReady = rst && clk_en && ((state_q == RES_EMPTY) || ResultReady);
  assign fire_c    = InstValid && InstReady;

  alu_issue_regfile #(
    .BITWIDTH (BITWIDTH),
    .REGCOUNT (REGCOUNT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (fire_c),
    .waddr   (REGADDR'(inst_c.dest)),
    .wdata   (Data_OutC),
    .raddr_a (REGADDR'(inst_c.src_a)),
    .rdata_a (rd_a_c),
    .raddr_b (REGADDR'(inst_c.src_b)),
    .rdata_b (rd_b_c)
  );

  assign ALU_Enable = fire_c;
  assign Opcode     = fire_c ? 4'(inst_c.opcode) : 4'h0;
  assign Data_InA   = fire_c ? rd_a_c : '0;
  assign Data_InB   = fire_c ? (inst_c.imm_en ? BITWIDTH'(inst_c.imm) : rd_b_c) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RES_EMPTY;
      res_q      <= '0;
      IssueCount <= '0;
      StallCount <= '0;
    end else if (clk_en) begin
      case (state_q)
        RES_EMPTY: if (fire_c) state_q <= RES_FULL;
        RES_FULL:  if (ResultReady && !fire_c) state_q <= RES_EMPTY;
      endcase
      if (fire_c) begin
        res_q      <= '{dest: REG_ADDR_W'(InstDest), data: DATA_W'(Data_OutC)};
        IssueCount <= IssueCount + CNTWIDTH'(1);
      end
      if ((state_q == RES_FULL) && !ResultReady && (StallCount != '1)) begin
        StallCount <= StallCount + CNTWIDTH'(1);
      end
    end
  end

  assign ResultValid = (state_q == RES_FULL);
  assign ResultDest  = REGADDR'(res_q.dest);
  assign ResultData  = BITWIDTH'(res_q.data);

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with an XOR stub ALU and a result scoreboard.
module tb_alu_issue_unit;

  typedef struct {
    logic [3:0]  dest;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        InstValid;
  logic        InstReady;
  logic [3:0]  InstOpcode;
  logic [3:0]  InstDest;
  logic [3:0]  InstSrcA;
  logic [3:0]  InstSrcB;
  logic        InstImmEn;
  logic [15:0] InstImm;
  logic [15:0] Data_InA;
  logic [15:0] Data_InB;
  logic        ALU_Enable;
  logic [3:0]  Opcode;
  logic [15:0] Data_OutC;
  logic        ResultValid;
  logic        ResultReady;
  logic [3:0]  ResultDest;
  logic [15:0] ResultData;
  logic [31:0] IssueCount;
  logic [31:0] StallCount;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_r [16];
  logic [31:0] exp_issue;
  logic [31:0] exp_stall;
  exp_t        sb [$];

  always #5 clk = ~clk;

  assign Data_OutC = Data_InA ^ Data_InB;

  alu_issue_unit dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .InstValid   (InstValid),
    .InstReady   (InstReady),
    .InstOpcode  (InstOpcode),
    .InstDest    (InstDest),
    .InstSrcA    (InstSrcA),
    .InstSrcB    (InstSrcB),
    .InstImmEn   (InstImmEn),
    .InstImm     (InstImm),
    .Data_InA    (Data_InA),
    .Data_InB    (Data_InB),
    .ALU_Enable  (ALU_Enable),
    .Opcode      (Opcode),
    .Data_OutC   (Data_OutC),
    .ResultValid (ResultValid),
    .ResultReady (ResultReady),
    .ResultDest  (ResultDest),
    .ResultData  (ResultData),
    .IssueCount  (IssueCount),
    .StallCount  (StallCount)
  );

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_r[i] = 16'h0;
    exp_issue = 0;
    exp_stall = 0;
    sb.delete();
  endtask

  // Drive one op with ResultReady=1, check the ALU drive and the resulting held entry.
  task automatic issue(input string nm, input logic [3:0] op, input logic [3:0] dest,
                       input logic [3:0] sa, input logic [3:0] sb_reg,
                       input logic ie, input logic [15:0] imm);
    logic [15:0] ea, eb;
    logic        consumed;
    exp_t        e;
    @(negedge clk);
    InstValid = 1'b1; InstOpcode = op; InstDest = dest; InstSrcA = sa; InstSrcB = sb_reg;
    InstImmEn = ie; InstImm = imm; ResultReady = 1'b1;
    #1;
    ea = model_r[sa];
    eb = ie ? imm : model_r[sb_reg];
    checks++; if (InstReady !== 1'b1) begin errors++; $display("FAIL %s ready got %b exp 1", nm, InstReady); end
    checks++; if (ALU_Enable !== 1'b1) begin errors++; $display("FAIL %s alu_en got %b exp 1", nm, ALU_Enable); end
    checks++; if (Opcode !== op) begin errors++; $display("FAIL %s opcode got %h exp %h", nm, Opcode, op); end
    checks++; if (Data_InA !== ea) begin errors++; $display("FAIL %s in_a got %h exp %h", nm, Data_InA, ea); end
    checks++; if (Data_InB !== eb) begin errors++; $display("FAIL %s in_b got %h exp %h", nm, Data_InB, eb); end
    consumed = (ResultValid === 1'b1);
    @(posedge clk);
    #1;
    InstValid = 1'b0;
    if (consumed && sb.size() > 0) void'(sb.pop_front());
    e.dest = dest;
    e.data = ea ^ eb;
    sb.push_back(e);
    if (dest != 4'd0) model_r[dest] = ea ^ eb;
    exp_issue++;
    checks++; if (ResultValid !== 1'b1) begin errors++; $display("FAIL %s res_valid got %b exp 1", nm, ResultValid); end
    checks++; if (ResultDest !== sb[0].dest) begin errors++; $display("FAIL %s res_dest got %h exp %h", nm, ResultDest, sb[0].dest); end
    checks++; if (ResultData !== sb[0].data) begin errors++; $display("FAIL %s res_data got %h exp %h", nm, ResultData, sb[0].data); end
    checks++; if (IssueCount !== exp_issue) begin errors++; $display("FAIL %s issue_cnt got %0d exp %0d", nm, IssueCount, exp_issue); end
  endtask

  task automatic test_reset();
    rst = 1'b0; clk_en = 1'b1; InstValid = 1'b1; ResultReady = 1'b0;
    InstOpcode = 4'h1; InstDest = 4'h1; InstSrcA = 4'h0; InstSrcB = 4'h0;
    InstImmEn = 1'b1; InstImm = 16'hffff;
    model_clear();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (InstReady !== 1'b0) begin errors++; $display("FAIL reset ready got %b exp 0", InstReady); end
      checks++; if (ALU_Enable !== 1'b0) begin errors++; $display("FAIL reset alu_en got %b exp 0", ALU_Enable); end
      @(posedge clk); #1;
      checks++; if (ResultValid !== 1'b0) begin errors++; $display("FAIL reset res_valid got %b exp 0", ResultValid); end
      checks++; if (IssueCount !== 32'd0) begin errors++; $display("FAIL reset issue_cnt got %0d exp 0", IssueCount); end
      checks++; if (StallCount !== 32'd0) begin errors++; $display("FAIL reset stall_cnt got %0d exp 0", StallCount); end
    end
    @(negedge clk);
    InstValid = 1'b0; rst = 1'b1;
  endtask

  task automatic test_imm_issue();
    issue("imm", 4'd5, 4'd3, 4'd0, 4'd0, 1'b1, 16'h8001);
  endtask

  task automatic test_back_to_back_raw();
    issue("raw", 4'd2, 4'd4, 4'd3, 4'd3, 1'b0, 16'h0000);
    issue("raw_r4", 4'd9, 4'd8, 4'd4, 4'd3, 1'b0, 16'h0000);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ResultReady = 1'b0; InstValid = 1'b1; InstOpcode = 4'd7; InstDest = 4'd5;
    InstSrcA = 4'd3; InstImmEn = 1'b1; InstImm = 16'h00ff;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (InstReady !== 1'b0) begin errors++; $display("FAIL bp ready got %b exp 0", InstReady); end
      checks++; if (ALU_Enable !== 1'b0) begin errors++; $display("FAIL bp alu_en got %b exp 0", ALU_Enable); end
      @(posedge clk); #1;
      exp_stall++;
      checks++; if (ResultData !== sb[0].data) begin errors++; $display("FAIL bp res_data got %h exp %h", ResultData, sb[0].data); end
      checks++; if (ResultValid !== 1'b1) begin errors++; $display("FAIL bp res_valid got %b exp 1", ResultValid); end
    end
    checks++; if (StallCount !== exp_stall) begin errors++; $display("FAIL bp stall_cnt got %0d exp %0d", StallCount, exp_stall); end
    issue("bp_release", 4'd7, 4'd5, 4'd3, 4'd0, 1'b1, 16'h00ff);
    checks++; if (StallCount !== exp_stall) begin errors++; $display("FAIL bp stall_hold got %0d exp %0d", StallCount, exp_stall); end
  endtask

  task automatic test_r0();
    issue("r0_write", 4'd3, 4'd0, 4'd5, 4'd0, 1'b1, 16'h1234);
    issue("r0_read", 4'd4, 4'd6, 4'd0, 4'd0, 1'b1, 16'h0f0f);
  endtask

  task automatic test_freeze_abort();
    @(negedge clk);
    clk_en = 1'b0; ResultReady = 1'b1; InstValid = 1'b1; InstOpcode = 4'hf;
    InstDest = 4'd9; InstSrcA = 4'd3; InstImmEn = 1'b1; InstImm = 16'h5555;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (InstReady !== 1'b0) begin errors++; $display("FAIL frz ready got %b exp 0", InstReady); end
      checks++; if (ALU_Enable !== 1'b0) begin errors++; $display("FAIL frz alu_en got %b exp 0", ALU_Enable); end
      @(posedge clk); #1;
      checks++; if (ResultValid !== 1'b1) begin errors++; $display("FAIL frz res_valid got %b exp 1", ResultValid); end
      checks++; if (ResultData !== sb[0].data) begin errors++; $display("FAIL frz res_data got %h exp %h", ResultData, sb[0].data); end
      checks++; if (IssueCount !== exp_issue) begin errors++; $display("FAIL frz issue_cnt got %0d exp %0d", IssueCount, exp_issue); end
      checks++; if (StallCount !== exp_stall) begin errors++; $display("FAIL frz stall_cnt got %0d exp %0d", StallCount, exp_stall); end
    end
    @(negedge clk);
    rst = 1'b0; InstValid = 1'b0;
    @(posedge clk); #1;
    model_clear();
    checks++; if (ResultValid !== 1'b0) begin errors++; $display("FAIL abort res_valid got %b exp 0", ResultValid); end
    checks++; if (IssueCount !== 32'd0) begin errors++; $display("FAIL abort issue_cnt got %0d exp 0", IssueCount); end
    checks++; if (StallCount !== 32'd0) begin errors++; $display("FAIL abort stall_cnt got %0d exp 0", StallCount); end
    @(negedge clk);
    rst = 1'b1; clk_en = 1'b1;
    issue("abort_r3", 4'd1, 4'd7, 4'd3, 4'd3, 1'b0, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_imm_issue();
    test_back_to_back_raw();
    test_backpressure();
    test_r0();
    test_freeze_abort();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
